// File: rtl/branch_resolve_unit_pkg.sv
// Shared RV32I branch types: op encoding, resolved-result record and the
// direction evaluation used by the branch resolve unit.
package rv32i_types;

  localparam int RV_XLEN   = 32;
  localparam int RV_TAG_W  = 5;
  localparam int RV_PREG_W = 6;

  typedef enum logic [2:0] {
    BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
  } br_op_t;

  typedef struct packed {
    logic [RV_TAG_W-1:0]  rob_tag;
    logic [RV_PREG_W-1:0] pd;
    logic                 rd_we;
    logic [RV_XLEN-1:0]   link;
    logic                 taken;
    logic [RV_XLEN-1:0]   target;
    logic                 mispredict;
    logic [RV_XLEN-1:0]   redirect_pc;
    logic                 misaligned;
    logic [RV_XLEN-1:0]   rs1;
    logic [RV_XLEN-1:0]   rs2;
  } br_result_t;

  function automatic logic br_taken(input br_op_t op,
                                    input logic [RV_XLEN-1:0] a,
                                    input logic [RV_XLEN-1:0] b);
    case (op)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return $signed(a) <  $signed(b);
      BR_BGE:  return $signed(a) >= $signed(b);
      BR_BLTU: return a <  b;
      BR_BGEU: return a >= b;
      default: return 1'b1;  // JAL / JALR are unconditional
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// Circular result buffer between branch resolution and the CDB arbiter.
// Reads as all-zero when empty so the head port has a defined idle value.
module br_result_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  br_result_t                   push_data,
  input  logic                         pop,
  output br_result_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  br_result_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; validity lives in count, and head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution: S1 operand register, resolve logic, result FIFO,
// predictor-update pulse and saturating branch/mispredict counters.
module branch_resolve_unit
  import rv32i_types::*;
#(
  parameter int XLEN      = RV_XLEN,
  parameter int TAG_W     = RV_TAG_W,
  parameter int PREG_W    = RV_PREG_W,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  br_op_t            in_op,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic [PREG_W-1:0] in_pd,
  output logic              out_valid,
  input  logic              out_ready,
  output br_result_t        out_entry,
  output logic              upd_valid,
  output logic [XLEN-1:0]   upd_pc,
  output logic [XLEN-1:0]   upd_target,
  output logic              upd_taken,
  output logic              upd_is_cond,
  output logic [CNT_W-1:0]  perf_branches,
  output logic [CNT_W-1:0]  perf_mispredicts
);

  localparam int FCNT_W = $clog2(OUT_DEPTH + 1);

  logic              s1_valid;
  br_op_t            s1_op;
  logic [XLEN-1:0]   s1_pc, s1_imm, s1_rs1, s1_rs2, s1_pred_target;
  logic              s1_pred_taken;
  logic [TAG_W-1:0]  s1_rob_tag;
  logic [PREG_W-1:0] s1_pd;

  logic [FCNT_W-1:0] fifo_count;
  logic              accept, push, pop, is_cond;
  br_result_t        res;

  // Credit check counts the op in S1 so a push never finds the FIFO full.
  assign in_ready  = (32'(fifo_count) + 32'(s1_valid)) < 32'(OUT_DEPTH);
  assign accept    = in_valid && in_ready && !flush;
  assign push      = s1_valid && !flush;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) s1_valid <= 1'b0;
    else              s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op          <= in_op;
      s1_pc          <= in_pc;
      s1_imm         <= in_imm;
      s1_rs1         <= in_rs1;
      s1_rs2         <= in_rs2;
      s1_pred_taken  <= in_pred_taken;
      s1_pred_target <= in_pred_target;
      s1_rob_tag     <= in_rob_tag;
      s1_pd          <= in_pd;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    res             = '0;
    is_cond         = !(s1_op inside {BR_JAL, BR_JALR});
    res.rob_tag     = s1_rob_tag;
    res.pd          = s1_pd;
    res.rs1         = s1_rs1;
    res.rs2         = s1_rs2;
    res.taken       = br_taken(s1_op, s1_rs1, s1_rs2);
    res.target      = (s1_op == BR_JALR) ? ((s1_rs1 + s1_imm) & ~XLEN'(1))
                                         : (s1_pc + s1_imm);
    if (!is_cond) begin
      res.rd_we = 1'b1;
      res.link  = s1_pc + XLEN'(4);
    end
    res.mispredict  = (res.taken != s1_pred_taken) ||
                      (res.taken && (res.target != s1_pred_target));
    res.redirect_pc = res.taken ? res.target : (s1_pc + XLEN'(4));
    res.misaligned  = res.taken && res.target[1];
  end

  br_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (res),
    .pop       (pop),
    .head      (out_entry),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_target  <= '0;
      upd_taken   <= 1'b0;
      upd_is_cond <= 1'b0;
    end else begin
      upd_valid <= push && !res.misaligned;
      if (push) begin
        upd_pc      <= s1_pc;
        upd_target  <= res.target;
        upd_taken   <= res.taken;
        upd_is_cond <= is_cond;
      end
    end
  end

  // Counters ignore flush; killed ops never reach push.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (push) begin
      if (perf_branches != '1) perf_branches <= perf_branches + CNT_W'(1);
      if (res.mispredict && (perf_mispredicts != '1))
        perf_mispredicts <= perf_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (OUT_DEPTH=2).
module tb_branch_resolve_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_pred_taken;
  logic        out_valid, out_ready, upd_valid, upd_taken, upd_is_cond;
  br_op_t      in_op;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
  logic [31:0] upd_pc, upd_target, perf_branches, perf_mispredicts;
  logic [4:0]  in_rob_tag;
  logic [5:0]  in_pd;
  br_result_t  out_entry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN(32), .TAG_W(5), .PREG_W(6), .OUT_DEPTH(2), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_rob_tag(in_rob_tag), .in_pd(in_pd),
    .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_is_cond(upd_is_cond),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  function automatic br_result_t exp_res(
    input logic [4:0] tag, input logic [5:0] pd, input logic rd_we,
    input logic [31:0] link, input logic taken, input logic [31:0] target,
    input logic misp, input logic [31:0] redir, input logic misal,
    input logic [31:0] rs1, input logic [31:0] rs2);
    br_result_t r;
    r.rob_tag = tag;  r.pd = pd;  r.rd_we = rd_we;  r.link = link;
    r.taken = taken;  r.target = target;  r.mispredict = misp;
    r.redirect_pc = redir;  r.misaligned = misal;  r.rs1 = rs1;  r.rs2 = rs2;
    return r;
  endfunction

  task automatic drive(input br_op_t op, input logic [31:0] pc, imm, rs1, rs2,
                       input logic pt, input logic [31:0] ptgt,
                       input logic [4:0] tag, input logic [5:0] pd);
    in_op = op;  in_pc = pc;  in_imm = imm;  in_rs1 = rs1;  in_rs2 = rs2;
    in_pred_taken = pt;  in_pred_target = ptgt;  in_rob_tag = tag;  in_pd = pd;
  endtask

  // Issue one op and return #1 after the edge that pushes it into the FIFO.
  task automatic do_op(input br_op_t op, input logic [31:0] pc, imm, rs1, rs2,
                       input logic pt, input logic [31:0] ptgt,
                       input logic [4:0] tag, input logic [5:0] pd);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready tag=%0d: got %b expected 1", tag, in_ready);
    end
    drive(op, pc, imm, rs1, rs2, pt, ptgt, tag, pd);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;  flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    drive(BR_BEQ, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_entry !== '0) begin n_fail++; $display("FAIL reset_out_entry: got %h expected 0", out_entry); end
    n_checks++; if ({upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond} !== '0) begin n_fail++; $display("FAIL reset_upd: got %b/%h/%h expected zeros", upd_valid, upd_pc, upd_target); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== 64'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_branches, perf_mispredicts); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_beq;
    br_result_t e;
    do_op(BR_BEQ, 32'h1000, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 5'd3, 6'd10);
    e = exp_res(3, 10, 0, 0, 1, 32'h1020, 1, 32'h1020, 0, 32'd5, 32'd5);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL beq_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL beq_entry: got %h expected %h", out_entry, e); end
    n_checks++; if ({upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond} !== {1'b1, 32'h1000, 32'h1020, 1'b1, 1'b1}) begin n_fail++; $display("FAIL beq_upd: got %b %h %h %b %b expected 1 1000 1020 1 1", upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL beq_perf: got %0d/%0d expected 1/1", perf_branches, perf_mispredicts); end
    @(posedge clk); #1;
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL beq_upd_pulse: got %b expected 0", upd_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL beq_popped: got %b expected 0", out_valid); end
  endtask

  task automatic test_signed_unsigned;
    br_result_t e;
    do_op(BR_BLT, 32'h2000, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h2010, 5'd4, 6'd11);
    e = exp_res(4, 11, 0, 0, 1, 32'h2010, 0, 32'h2010, 0, 32'hFFFF_FFFF, 32'd1);
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL blt_entry: got %h expected %h", out_entry, e); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL blt_perf: got %0d/%0d expected 2/1", perf_branches, perf_mispredicts); end
    do_op(BR_BLTU, 32'h2000, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h2010, 5'd5, 6'd11);
    e = exp_res(5, 11, 0, 0, 0, 32'h2010, 1, 32'h2004, 0, 32'hFFFF_FFFF, 32'd1);
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL bltu_entry: got %h expected %h", out_entry, e); end
    n_checks++; if ({upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond} !== {1'b1, 32'h2000, 32'h2010, 1'b0, 1'b1}) begin n_fail++; $display("FAIL bltu_upd: got %b %h %h %b %b expected 1 2000 2010 0 1", upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd3, 32'd2}) begin n_fail++; $display("FAIL bltu_perf: got %0d/%0d expected 3/2", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_jalr;
    br_result_t e;
    // 0x3002 has bit 1 set, so this correctly-predicted target is still misaligned.
    do_op(BR_JALR, 32'h500, 32'h0, 32'h3003, 32'h0, 1'b1, 32'h3002, 5'd6, 6'd12);
    e = exp_res(6, 12, 1, 32'h504, 1, 32'h3002, 0, 32'h3002, 1, 32'h3003, 32'h0);
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL jalr_clear_bit0: got %h expected %h", out_entry, e); end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_clear_bit0_upd: got %b expected 0", upd_valid); end
    do_op(BR_JALR, 32'h500, 32'h0, 32'h3001, 32'h0, 1'b1, 32'h3002, 5'd7, 6'd12);
    e = exp_res(7, 12, 1, 32'h504, 1, 32'h3000, 1, 32'h3000, 0, 32'h3001, 32'h0);
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL jalr_mispredict: got %h expected %h", out_entry, e); end
    n_checks++; if ({upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond} !== {1'b1, 32'h500, 32'h3000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL jalr_upd: got %b %h %h %b %b expected 1 500 3000 1 0", upd_valid, upd_pc, upd_target, upd_taken, upd_is_cond); end
    do_op(BR_JALR, 32'h500, 32'h0, 32'h3006, 32'h0, 1'b1, 32'h3006, 5'd8, 6'd12);
    e = exp_res(8, 12, 1, 32'h504, 1, 32'h3006, 0, 32'h3006, 1, 32'h3006, 32'h0);
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL jalr_misaligned: got %h expected %h", out_entry, e); end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_misaligned_upd: got %b expected 0", upd_valid); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd6, 32'd3}) begin n_fail++; $display("FAIL jalr_perf: got %0d/%0d expected 6/3", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_jal_wrap;
    br_result_t e;
    do_op(BR_JAL, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1'b1, 32'h4, 5'd9, 6'd13);
    e = exp_res(9, 13, 1, 32'h0, 1, 32'h4, 0, 32'h4, 0, 32'h0, 32'h0);
    n_checks++; if (out_entry !== e) begin n_fail++; $display("FAIL jal_wrap_entry: got %h expected %h", out_entry, e); end
    n_checks++; if ({upd_valid, upd_pc, upd_target} !== {1'b1, 32'hFFFF_FFFC, 32'h4}) begin n_fail++; $display("FAIL jal_wrap_upd: got %b %h %h expected 1 fffffffc 4", upd_valid, upd_pc, upd_target); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd7, 32'd3}) begin n_fail++; $display("FAIL jal_wrap_perf: got %0d/%0d expected 7/3", perf_branches, perf_mispredicts); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    br_result_t e_a;
    int         acc = 0;
    int         popped = 0;
    logic [4:0] got [3];
    logic       rdy, ov;
    logic [4:0] tg;
    e_a = exp_res(1, 7, 0, 0, 0, 32'h108, 0, 32'h104, 0, 32'd1, 32'd2);
    out_ready = 1'b0;
    drive(BR_BEQ, 32'h100, 32'h8, 32'd1, 32'd2, 1'b0, 32'h0, 5'd1, 6'd7);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid && acc < 3) begin
        acc++;
        if (acc < 3)
          drive(BR_BEQ, 32'h100 + 32'(4 * acc), 32'h8, 32'd1, 32'd2, 1'b0, 32'h0, 5'(acc + 1), 6'd7);
      end
    end
    n_checks++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      n_checks++; if (out_entry !== e_a || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_stable cyc%0d: got %b %h expected 1 %h", cyc, out_valid, out_entry, e_a); end
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && popped < 3; cyc++) begin
      @(negedge clk); ov = out_valid; tg = out_entry.rob_tag; rdy = in_ready;
      @(posedge clk); #1;
      if (ov) begin got[popped] = tg; popped++; end
      if (rdy && in_valid) in_valid = 1'b0;
    end
    n_checks++; if (popped !== 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 3", popped); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (i < popped && got[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL bp_order%0d: got tag %0d expected %0d", i, got[i], i + 1); end
    end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL bp_third_accepted: got in_valid %b expected 0", in_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd10, 32'd3}) begin n_fail++; $display("FAIL bp_perf: got %0d/%0d expected 10/3", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(BR_BEQ, 32'h200, 32'h8, 32'd3, 32'd3, 1'b1, 32'h208, 5'd11, 6'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(BR_BEQ, 32'h204, 32'h8, 32'd3, 32'd4, 1'b1, 32'h20C, 5'd12, 6'd1);
    @(posedge clk); #1;
    n_checks++; if ({out_valid, upd_valid, perf_branches} !== {1'b1, 1'b1, 32'd11}) begin n_fail++; $display("FAIL flush_pre: got %b %b %0d expected 1 1 11", out_valid, upd_valid, perf_branches); end
    drive(BR_JAL, 32'h300, 32'h8, 32'd0, 32'd0, 1'b0, 32'h0, 5'd13, 6'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;  in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_upd: got %b expected 0", upd_valid); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd11, 32'd3}) begin n_fail++; $display("FAIL flush_perf: got %0d/%0d expected 11/3", perf_branches, perf_mispredicts); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if ({out_valid, upd_valid, perf_branches} !== {1'b0, 1'b0, 32'd11}) begin n_fail++; $display("FAIL flush_dropped: got %b %b %0d expected 0 0 11", out_valid, upd_valid, perf_branches); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    do_op(BR_BNE, 32'h400, 32'h10, 32'd1, 32'd2, 1'b0, 32'h0, 5'd14, 6'd2);
    n_checks++; if ({perf_branches, perf_mispredicts} !== {32'd12, 32'd4}) begin n_fail++; $display("FAIL rstmid_pre_perf: got %0d/%0d expected 12/4", perf_branches, perf_mispredicts); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({out_valid, upd_valid, in_ready} !== 3'b001) begin n_fail++; $display("FAIL rstmid_flags: got %b%b%b expected 001", out_valid, upd_valid, in_ready); end
    n_checks++; if ({perf_branches, perf_mispredicts} !== 64'd0) begin n_fail++; $display("FAIL rstmid_perf: got %0d/%0d expected 0/0", perf_branches, perf_mispredicts); end
    n_checks++; if (out_entry !== '0) begin n_fail++; $display("FAIL rstmid_entry: got %h expected 0", out_entry); end
  endtask

  initial begin
    test_reset;
    test_beq;
    test_signed_unsigned;
    test_jalr;
    test_jal_wrap;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
